// File: rtl/dcache_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// dcache_ctrl_fsm_pkg
// Shared types and geometry defaults for the data-cache miss/flush controller.
//   dcache_state_t : controller FSM state encoding
//   Def*           : default associativity / block size / set count
//   clog2_min1()   : index width that never collapses to zero bits
// -----------------------------------------------------------------------------
package dcache_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWb,
        StFetch,
        StFlCheck,
        StFlWb,
        StDone
    } dcache_state_t;

    localparam int unsigned DefWays  = 2;
    localparam int unsigned DefWords = 2;
    localparam int unsigned DefSets  = 8;

    // Width of a counter/select that must exist even for a 1-entry dimension.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcache_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// dcache_ctrl_fsm_if
// Memory-side bus between the dcache controller and the memory arbiter.
//   dREN/dWEN  : read / write request (never both high)
//   daddr      : word address of the transfer
//   dstore     : write data
//   dwait      : memory busy; a transfer completes on a request cycle with dwait low
//   dload      : read data (written into the data array by the cache datapath)
// master = cache controller, slave = memory.
// -----------------------------------------------------------------------------
interface dcache_ctrl_fsm_if;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    modport master (
        output dREN,
        output dWEN,
        output daddr,
        output dstore,
        input  dwait,
        input  dload
    );

    modport slave (
        input  dREN,
        input  dWEN,
        input  daddr,
        input  dstore,
        output dwait,
        output dload
    );

endinterface

// File: rtl/dcache_walk_cnt.sv
// -----------------------------------------------------------------------------
// dcache_walk_cnt
// Modulo-Modulus counter used to walk words, ways and sets.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clr          : force to zero (wins over load/increment)
//   i_load         : load i_load_val (wins over increment)
//   i_inc          : advance by one, wrapping Modulus-1 -> 0
//   o_cnt          : current value
//   o_last         : o_cnt == Modulus-1 (always 1 when Modulus == 1)
// -----------------------------------------------------------------------------
module dcache_walk_cnt #(
    parameter int unsigned Modulus = 2,
    parameter int unsigned Width   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    input  logic             i_inc,
    output logic [Width-1:0] o_cnt,
    output logic             o_last
);

    localparam logic [Width-1:0] LastVal = Width'(Modulus - 1);

    logic [Width-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc) begin
            r_cnt <= (r_cnt == LastVal) ? '0 : r_cnt + Width'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == LastVal);

endmodule

// File: rtl/dcache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// dcache_ctrl_fsm
// Miss / flush controller for a WAYS-way, WORDS-per-block, SETS-set data cache.
// Services read/write misses (dirty victim writeback, then block fetch) and on
// halt walks every set/way, writing back dirty lines before raising flushed.
//   CLK, nRST                 : clock, synchronous active-low reset
//   dmemREN/dmemWEN/dmemaddr  : datapath request
//   halt                      : start flush
//   miss, lru_way             : lookup result / victim way for dmemaddr's set
//   way_valid/dirty/tag/word  : array contents at sel_set/sel_way/sel_word
//   mem                       : memory-side bus (master)
//   sel_set/sel_way/sel_word  : array select
//   fill_wen                  : write dload at sel_*
//   tag_wen                   : write dmemaddr tag, valid=1, dirty=0 at sel_set/sel_way
//   clean_wen                 : clear dirty at sel_set/sel_way
//   busy, flushed             : status
// SETS must be at least 2 (the set index needs one bit).
// -----------------------------------------------------------------------------
module dcache_ctrl_fsm
    import dcache_ctrl_fsm_pkg::*;
#(
    parameter  int unsigned WAYS  = DefWays,
    parameter  int unsigned WORDS = DefWords,
    parameter  int unsigned SETS  = DefSets,
    localparam int unsigned WAY_W = clog2_min1(WAYS),
    localparam int unsigned OFF_W = clog2_min1(WORDS),
    localparam int unsigned OFF_B = $clog2(WORDS),
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned TAG_W = 30 - IDX_W - OFF_B
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 dmemREN,
    input  logic                 dmemWEN,
    input  logic [31:0]          dmemaddr,
    input  logic                 halt,
    input  logic                 miss,
    input  logic [WAY_W-1:0]     lru_way,
    input  logic                 way_valid,
    input  logic                 way_dirty,
    input  logic [TAG_W-1:0]     way_tag,
    input  logic [31:0]          way_word,
    dcache_ctrl_fsm_if.master    mem,
    output logic [IDX_W-1:0]     sel_set,
    output logic [WAY_W-1:0]     sel_way,
    output logic [OFF_W-1:0]     sel_word,
    output logic                 fill_wen,
    output logic                 tag_wen,
    output logic                 clean_wen,
    output logic                 busy,
    output logic                 flushed
);

    dcache_state_t      r_state;
    logic [TAG_W-1:0]   r_tag;

    logic [OFF_W-1:0]   w_word;
    logic [WAY_W-1:0]   w_way;
    logic [IDX_W-1:0]   w_set;
    logic               w_word_last;
    logic               w_way_last;
    logic               w_set_last;

    logic [IDX_W-1:0]   w_req_set;
    logic [TAG_W-1:0]   w_req_tag;
    logic               w_req;
    logic               w_miss_start;
    logic               w_fl_start;
    logic               w_line_dirty;
    logic               w_xfer;
    logic               w_fl_adv;
    logic               w_walk_end;
    logic               w_unused;

    assign w_req_set    = dmemaddr[2 + OFF_B +: IDX_W];
    assign w_req_tag    = dmemaddr[31 -: TAG_W];
    assign w_req        = (dmemREN | dmemWEN) & miss;
    assign w_miss_start = (r_state == StIdle) & w_req;
    // A pending miss has priority over halt; the flush begins from a later IDLE.
    assign w_fl_start   = (r_state == StIdle) & ~w_req & halt;
    assign w_line_dirty = way_valid & way_dirty;
    // Every transfer state holds exactly one request high, so completion is !dwait.
    assign w_xfer       = ((r_state == StWb) || (r_state == StFetch) || (r_state == StFlWb))
                          & ~mem.dwait;
    assign w_fl_adv     = ((r_state == StFlCheck) & ~w_line_dirty)
                          | ((r_state == StFlWb) & w_xfer & w_word_last);
    assign w_walk_end   = w_fl_adv & w_way_last & w_set_last;

    // Byte-offset bits and fill data are consumed elsewhere in the cache.
    assign w_unused     = ^{dmemaddr[1:0], mem.dload};

    dcache_walk_cnt #(
        .Modulus (WORDS),
        .Width   (OFF_W)
    ) u_word_cnt (
        .i_clk      (CLK),
        .i_rst_n    (nRST),
        .i_clr      (1'b0),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (w_xfer),
        .o_cnt      (w_word),
        .o_last     (w_word_last)
    );

    dcache_walk_cnt #(
        .Modulus (WAYS),
        .Width   (WAY_W)
    ) u_way_cnt (
        .i_clk      (CLK),
        .i_rst_n    (nRST),
        .i_clr      (w_fl_start),
        .i_load     (w_miss_start),
        .i_load_val (lru_way),
        .i_inc      (w_fl_adv),
        .o_cnt      (w_way),
        .o_last     (w_way_last)
    );

    dcache_walk_cnt #(
        .Modulus (SETS),
        .Width   (IDX_W)
    ) u_set_cnt (
        .i_clk      (CLK),
        .i_rst_n    (nRST),
        .i_clr      (w_fl_start),
        .i_load     (w_miss_start),
        .i_load_val (w_req_set),
        .i_inc      (w_fl_adv & w_way_last),
        .o_cnt      (w_set),
        .o_last     (w_set_last)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= StIdle;
            r_tag   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_miss_start) begin
                        r_tag   <= w_req_tag;
                        r_state <= w_line_dirty ? StWb : StFetch;
                    end else if (w_fl_start) begin
                        r_state <= StFlCheck;
                    end
                end
                StWb: begin
                    if (w_xfer && w_word_last) r_state <= StFetch;
                end
                StFetch: begin
                    if (w_xfer && w_word_last) r_state <= StIdle;
                end
                StFlCheck: begin
                    if (w_line_dirty)    r_state <= StFlWb;
                    else if (w_walk_end) r_state <= StDone;
                end
                StFlWb: begin
                    if (w_xfer && w_word_last) r_state <= w_walk_end ? StDone : StFlCheck;
                end
                StDone: r_state <= StDone;
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem.dREN   = 1'b0;
        mem.dWEN   = 1'b0;
        mem.daddr  = '0;
        mem.dstore = '0;
        fill_wen   = 1'b0;
        tag_wen    = 1'b0;
        clean_wen  = 1'b0;
        sel_set    = w_set;
        sel_way    = w_way;
        sel_word   = w_word;
        busy       = (r_state != StIdle) && (r_state != StDone);
        flushed    = (r_state == StDone);

        unique case (r_state)
            StIdle: begin
                sel_set = w_req_set;
                sel_way = lru_way;
            end
            StWb, StFlWb: begin
                // Victim address comes from the stored tag of the line being evicted.
                mem.dWEN   = 1'b1;
                mem.daddr  = (32'(way_tag) << (32 - TAG_W))
                             | (32'(w_set) << (2 + OFF_B))
                             | (32'(w_word) << 2);
                mem.dstore = way_word;
                clean_wen  = (r_state == StFlWb) & w_xfer & w_word_last;
            end
            StFetch: begin
                mem.dREN  = 1'b1;
                mem.daddr = (32'(r_tag) << (32 - TAG_W))
                            | (32'(w_set) << (2 + OFF_B))
                            | (32'(w_word) << 2);
                fill_wen  = w_xfer;
                tag_wen   = w_xfer & w_word_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_dcache_ctrl_fsm
// Directed bench for dcache_ctrl_fsm: instance A uses the default 2x2x8
// geometry with a small line-state table, instance B uses 4 ways, 4 words,
// 4 sets with one fixed dirty line (set 2, way 3).
// -----------------------------------------------------------------------------
module tb_dcache_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;
    int   n_checks = 0;
    int   n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // ---------------- instance A: WAYS=2, WORDS=2, SETS=8 ----------------
    logic        a_ren, a_wen, a_halt, a_miss, a_lru;
    logic [31:0] a_addr;
    logic        a_valid, a_dirty;
    logic [25:0] a_tag;
    logic [31:0] a_word;
    logic [2:0]  a_sel_set;
    logic        a_sel_way, a_sel_word;
    logic        a_fill, a_tagw, a_clean, a_busy, a_flushed;

    logic        lv [8][2];
    logic        ld [8][2];
    logic [25:0] lt [8][2];
    logic [31:0] lw [8][2][2];

    always_comb begin
        a_valid = lv[a_sel_set][a_sel_way];
        a_dirty = ld[a_sel_set][a_sel_way];
        a_tag   = lt[a_sel_set][a_sel_way];
        a_word  = lw[a_sel_set][a_sel_way][a_sel_word];
    end

    dcache_ctrl_fsm_if a_mem ();

    dcache_ctrl_fsm #(
        .WAYS  (2),
        .WORDS (2),
        .SETS  (8)
    ) u_dut_a (
        .CLK       (clk),
        .nRST      (nrst),
        .dmemREN   (a_ren),
        .dmemWEN   (a_wen),
        .dmemaddr  (a_addr),
        .halt      (a_halt),
        .miss      (a_miss),
        .lru_way   (a_lru),
        .way_valid (a_valid),
        .way_dirty (a_dirty),
        .way_tag   (a_tag),
        .way_word  (a_word),
        .mem       (a_mem),
        .sel_set   (a_sel_set),
        .sel_way   (a_sel_way),
        .sel_word  (a_sel_word),
        .fill_wen  (a_fill),
        .tag_wen   (a_tagw),
        .clean_wen (a_clean),
        .busy      (a_busy),
        .flushed   (a_flushed)
    );

    // ---------------- instance B: WAYS=4, WORDS=4, SETS=4 ----------------
    logic        b_ren, b_wen, b_halt, b_miss;
    logic [1:0]  b_lru;
    logic [31:0] b_addr;
    logic        b_valid, b_dirty;
    logic [25:0] b_tag;
    logic [31:0] b_word;
    logic [1:0]  b_sel_set, b_sel_way, b_sel_word;
    logic        b_fill, b_tagw, b_clean, b_busy, b_flushed;

    always_comb begin
        b_valid = (b_sel_set == 2'd2) && (b_sel_way == 2'd3);
        b_dirty = b_valid;
        b_tag   = 26'h9;
        b_word  = 32'hB0 + 32'(b_sel_word);
    end

    dcache_ctrl_fsm_if b_mem ();

    dcache_ctrl_fsm #(
        .WAYS  (4),
        .WORDS (4),
        .SETS  (4)
    ) u_dut_b (
        .CLK       (clk),
        .nRST      (nrst),
        .dmemREN   (b_ren),
        .dmemWEN   (b_wen),
        .dmemaddr  (b_addr),
        .halt      (b_halt),
        .miss      (b_miss),
        .lru_way   (b_lru),
        .way_valid (b_valid),
        .way_dirty (b_dirty),
        .way_tag   (b_tag),
        .way_word  (b_word),
        .mem       (b_mem),
        .sel_set   (b_sel_set),
        .sel_way   (b_sel_way),
        .sel_word  (b_sel_word),
        .fill_wen  (b_fill),
        .tag_wen   (b_tagw),
        .clean_wen (b_clean),
        .busy      (b_busy),
        .flushed   (b_flushed)
    );

    task automatic clear_lines();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 2; w++) begin
                lv[s][w] = 1'b0;
                ld[s][w] = 1'b0;
                lt[s][w] = '0;
                lw[s][w][0] = '0;
                lw[s][w][1] = '0;
            end
        end
    endtask

    logic [31:0] exp_a_addr [4];
    logic [31:0] exp_a_data [4];

    initial begin
        int wb;
        int cl;
        int fl_cyc;

        nrst = 1'b0;
        a_ren = 0; a_wen = 0; a_halt = 0; a_miss = 0; a_lru = 1'b1; a_addr = 32'h48;
        b_ren = 0; b_wen = 0; b_halt = 0; b_miss = 0; b_lru = 2'd0; b_addr = 32'h0;
        a_mem.dwait = 1'b0; a_mem.dload = '0;
        b_mem.dwait = 1'b0; b_mem.dload = '0;
        clear_lines();

        // ---- reset state ----
        cyc(); cyc(); smp();
        check("rst_ctl", {a_busy, a_flushed, a_mem.dREN, a_mem.dWEN, a_fill, a_tagw, a_clean}, 0);
        check("rst_daddr", a_mem.daddr, 32'h0);
        check("rst_sel", {a_sel_set, a_sel_way, a_sel_word}, {3'd1, 1'b1, 1'b0});

        // ---- clean read miss at 0x48, lru_way=1: tag 1, set 1 ----
        cyc(); nrst = 1'b1; a_ren = 1'b1; a_miss = 1'b1;
        smp();
        check("m1_idle_busy", a_busy, 0);
        for (int w = 0; w < 2; w++) begin
            cyc(); smp();
            check("m1_ren", {a_mem.dREN, a_mem.dWEN, a_fill}, 3'b101);
            check("m1_daddr", a_mem.daddr, 32'h48 + 32'(4 * w));
            check("m1_tagw", a_tagw, (w == 1));
        end
        cyc(); a_ren = 0; a_miss = 0;
        smp();
        check("m1_back_idle", {a_busy, a_mem.dREN}, 0);

        // ---- dirty write miss: victim set 1 way 0 tag 0x155, new tag 2 ----
        lv[1][0] = 1; ld[1][0] = 1; lt[1][0] = 26'h155;
        lw[1][0][0] = 32'hA0; lw[1][0][1] = 32'hA1;
        cyc(); a_addr = 32'h88; a_lru = 1'b0; a_wen = 1'b1; a_miss = 1'b1;
        smp();
        check("m2_idle_sel", {a_busy, a_sel_set, a_sel_way}, {1'b0, 3'd1, 1'b0});
        for (int w = 0; w < 2; w++) begin
            cyc(); smp();
            check("m2_wb_req", {a_mem.dREN, a_mem.dWEN, a_fill}, 3'b010);
            check("m2_wb_daddr", a_mem.daddr, 32'h5548 + 32'(4 * w));
            check("m2_wb_dstore", a_mem.dstore, 32'hA0 + 32'(w));
        end
        for (int w = 0; w < 2; w++) begin
            cyc(); smp();
            check("m2_fe_req", {a_mem.dREN, a_mem.dWEN, a_fill, a_tagw}, {3'b101, (w == 1)});
            check("m2_fe_daddr", a_mem.daddr, 32'h88 + 32'(4 * w));
        end
        cyc(); a_wen = 0; a_miss = 0;
        smp();
        check("m2_back_idle", a_busy, 0);

        // ---- dwait high 3 cycles per word: clean miss at 0x110 (tag 4, set 2) ----
        cyc(); a_addr = 32'h110; a_ren = 1'b1; a_miss = 1'b1;
        smp();
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 4; k++) begin
                cyc(); a_mem.dwait = (k < 3);
                smp();
                check("m3_daddr", a_mem.daddr, 32'h110 + 32'(4 * w));
                check("m3_fill", {a_fill, a_tagw}, {(k == 3), (k == 3 && w == 1)});
            end
        end
        cyc(); a_ren = 0; a_miss = 0; a_mem.dwait = 1'b0;
        smp();
        check("m3_back_idle", a_busy, 0);

        // ---- halt during FETCH, then flush with set 0 / set 7 way 1 dirty ----
        clear_lines();
        lv[0][1] = 1; ld[0][1] = 1; lt[0][1] = 26'h3; lw[0][1][0] = 32'hC0; lw[0][1][1] = 32'hC1;
        lv[7][1] = 1; ld[7][1] = 1; lt[7][1] = 26'h7; lw[7][1][0] = 32'hD0; lw[7][1][1] = 32'hD1;
        exp_a_addr[0] = 32'hC0;  exp_a_addr[1] = 32'hC4;
        exp_a_addr[2] = 32'h1F8; exp_a_addr[3] = 32'h1FC;
        exp_a_data[0] = 32'hC0;  exp_a_data[1] = 32'hC1;
        exp_a_data[2] = 32'hD0;  exp_a_data[3] = 32'hD1;
        cyc(); a_addr = 32'h48; a_lru = 1'b1; a_ren = 1'b1; a_miss = 1'b1;
        smp();
        cyc(); a_halt = 1'b1;
        smp();
        check("h_fetch_w0", {a_mem.dREN, a_tagw}, 2'b10);
        cyc(); smp();
        check("h_fetch_tagw", {a_mem.dREN, a_tagw}, 2'b11);
        cyc(); a_ren = 0; a_miss = 0;
        smp();
        check("h_idle_between", a_busy, 0);
        wb = 0; cl = 0; fl_cyc = -1;
        for (int i = 0; i < 30; i++) begin
            cyc(); smp();
            if (a_mem.dWEN && !a_mem.dwait) begin
                if (wb < 4) begin
                    check("fl_a_daddr", a_mem.daddr, exp_a_addr[wb]);
                    check("fl_a_dstore", a_mem.dstore, exp_a_data[wb]);
                end
                wb++;
            end
            if (a_clean) cl++;
            if (a_flushed && fl_cyc < 0) fl_cyc = i;
        end
        check("fl_a_writes", wb, 4);
        check("fl_a_cleans", cl, 2);
        check("fl_a_flushed_cyc", fl_cyc, 20);

        // DONE holds and ignores both halt and new requests
        a_ren = 1'b1; a_miss = 1'b1;
        cyc(); smp();
        check("done_hold", {a_flushed, a_busy, a_mem.dREN, a_mem.dWEN}, 4'b1000);

        // ---- nRST low during WB word 1 ----
        cyc(); nrst = 1'b0; a_ren = 0; a_miss = 0; a_halt = 0;
        clear_lines();
        lv[1][0] = 1; ld[1][0] = 1; lt[1][0] = 26'h155;
        lw[1][0][0] = 32'hA0; lw[1][0][1] = 32'hA1;
        cyc(); nrst = 1'b1; a_addr = 32'h88; a_lru = 1'b0; a_wen = 1'b1; a_miss = 1'b1;
        smp();
        check("r_idle_after_done", {a_flushed, a_busy}, 0);
        cyc(); smp();
        check("r_wb_w0", a_mem.daddr, 32'h5548);
        cyc(); nrst = 1'b0;
        smp();
        check("r_wb_w1", a_mem.daddr, 32'h554C);
        cyc(); smp();
        check("r_reset_ctl", {a_busy, a_mem.dWEN, a_mem.dREN, a_fill, a_tagw}, 0);
        check("r_reset_daddr", a_mem.daddr, 32'h0);
        cyc(); nrst = 1'b1;
        smp();
        cyc(); smp();
        // Word counter restarted: writeback begins again at word 0.
        check("r_restart_w0", {a_mem.dWEN, a_mem.daddr}, {1'b1, 32'h5548});
        cyc(); cyc(); cyc();
        cyc(); a_wen = 0; a_miss = 0;
        smp();
        check("r_finish_idle", a_busy, 0);

        // ---- instance B: clean miss at 0x130 (tag 4, set 3, word 0) ----
        cyc(); b_addr = 32'h130; b_ren = 1'b1; b_miss = 1'b1;
        smp();
        check("b_idle_sel", {b_busy, b_sel_set, b_sel_way}, {1'b0, 2'd3, 2'd0});
        for (int w = 0; w < 4; w++) begin
            cyc(); smp();
            check("b_fe_daddr", b_mem.daddr, 32'h130 + 32'(4 * w));
            check("b_fe_ctl", {b_mem.dREN, b_fill, b_tagw}, {2'b11, (w == 3)});
        end
        cyc(); b_ren = 0; b_miss = 0;
        smp();
        check("b_back_idle", b_busy, 0);

        // ---- instance B flush: one dirty line at set 2 way 3, tag 9 ----
        cyc(); b_halt = 1'b1;
        smp();
        wb = 0; cl = 0; fl_cyc = -1;
        for (int i = 0; i < 30; i++) begin
            cyc(); smp();
            if (b_mem.dWEN && !b_mem.dwait) begin
                if (wb < 4) begin
                    check("fl_b_daddr", b_mem.daddr, 32'h260 + 32'(4 * wb));
                    check("fl_b_dstore", b_mem.dstore, 32'hB0 + 32'(wb));
                end
                wb++;
            end
            if (b_clean) cl++;
            if (b_flushed && fl_cyc < 0) fl_cyc = i;
        end
        check("fl_b_writes", wb, 4);
        check("fl_b_cleans", cl, 1);
        check("fl_b_flushed_cyc", fl_cyc, 20);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
